jump_sequencer: RTL and testbench
=================================

// Module: jump_sequencer
// PURPOSE
//  Next-generation jump-group control: owns the program counter and runs the FETCH/DECODE/EXECUTE/COMMIT phase FSM.
//  Evaluates Group-2 (GPF=2'b10) jumps: JP/JR, register or U8H.RBL target, conditional on a flag with optional invert.
//  Widths are parametrised. Adds fetch handshake, stall, HALT/WAKE and an optional call/return stack.
//  Sits between the instruction memory port and the ALU/register-file decoders; broadcasts phase strobes to them.
// PARAMETERS
//  ADDR_W        16      PC/address width, 8..32
//  NUM_CC        4       implemented flags, 1..4; CCF index >= NUM_CC reads as flag 0
//  RESET_VECTOR  0       PC value after reset
//  RSTACK_DEPTH  4       return-stack entries, power of 2 (used only with JUMP_RSTACK_EN)
// PORTS
//  CLK          in   1        clock, rising edge
//  RESET        in   1        asynchronous, active-high
//  INSTRUCTION  in   16       fetched word; valid with INSTR_VALID
//  INSTR_VALID  in   1        memory returns INSTRUCTION for the current PC
//  REGB_DATA    in   ADDR_W   register-B value (ARGB register, or RB when JPF[0]=1)
//  FLAGS        in   NUM_CC   condition flags from the ALU
//  STALL        in   1        hold in EXECUTE
//  WAKE         in   1        leave HALT
//  PC           out  ADDR_W   program counter
//  PC_VALID     out  1        fetch request, high in FETCH
//  FETCH/DECODE/EXECUTE/COMMIT  out 1 each  one-hot phase strobes
//  REGB_SEL_RB  out  1        1 = drive RB onto REGB_DATA (JPF[0]); 0 = ARGB register
//  JMP_TAKEN    out  1        one-cycle pulse in COMMIT when PC is loaded with the target
//  HALTED       out  1        high while in HALT
//  RSTACK_OVF/RSTACK_UNF  out 1 each  sticky; exist only with JUMP_RSTACK_EN
// BEHAVIOUR
//  Reset: PC=RESET_VECTOR, state FETCH, IR=0; all other outputs 0 except PC_VALID=1 and FETCH=1; sticky flags 0.
//  FSM: FETCH -(INSTR_VALID)-> DECODE -> EXECUTE -(!STALL)-> COMMIT -> FETCH.
//   - FETCH waits indefinitely; IR latches on the INSTR_VALID edge.
//   - COMMIT goes to HALT instead when IR == `INSTRUCTION_HALT`. PC is still advanced by 1 in that COMMIT.
//   - HALT -(WAKE)-> FETCH. In HALT, INSTR_VALID is ignored and PC is frozen.
//  Minimum 4 cycles per instruction. PC changes only on the COMMIT->next edge.
//  Fields of IR: SKIPF=[13:12], JPF=[11:10], CCF=[9:8], U8=[7:0].
//  OPERAND (registered in EXECUTE, together with FLAGS):
//   - JPF[0]=1: {U8, REGB_DATA[7:0]}, zero-extended, or truncated to ADDR_W.
//   - JPF[0]=0: REGB_DATA.
//  COND = SKIPF[1] ? (FLAGS[CCF] ^ SKIPF[0]) : 1. TAKE = (GPF==2'b10) & COND.
//  TARGET:
//   - JR (JPF[1]=1): PC+1+sext16(OPERAND[15:0]), modulo 2^ADDR_W (wraps).
//   - JP: OPERAND.
//  PC_next = TAKE ? TARGET : PC+1; wraps at 2^ADDR_W-1 to 0.
//  Non-jump groups always advance by 1.
//  Boundaries:
//   - STALL is ignored outside EXECUTE.
//   - WAKE together with RESET: RESET wins.
//   - RESET mid-phase aborts the instruction; no PC update and no pulse.
// CONFIGURATION
//  JUMP_RSTACK_EN defined:
//   - SKIPF=2'b01 is a return-stack op.
//     * JPF=2'b11 is RET: pop into PC.
//     * Any other JPF is CALL: push PC+1, then jump to TARGET.
//   - Push when full overwrites the oldest entry (circular) and sets RSTACK_OVF.
//   - Pop when empty gives PC+1 and sets RSTACK_UNF.
//   - Push and pop occur in COMMIT only.
//   - JMP_TAKEN pulses for both CALL and RET.
//  JUMP_RSTACK_EN undefined:
//   - SKIPF=2'b01 is an unconditional jump, identical to 2'b00.
//   - No stack; RSTACK_* ports are absent.
// STRUCTURE
//  `constants.v` gains: GROUP_JUMP, INSTRUCTION_HALT, the FSM state encodings, and SKIPF/JPF field positions.
//  Sub-module jump_rstack (DEPTH, W): push/pop/data/full/empty/ovf/unf. Instantiated only under JUMP_RSTACK_EN.
// TESTING
//  1 Reset with RESET_VECTOR=16'h0100, then 3 NOPs, INSTR_VALID each FETCH -> PC 0100,0101,0102,0103. Phase strobes one-hot, 4 cycles each.
//  2 At PC=16'h0010, JR with REGB_DATA=16'hFFFE -> PC=16'h000F, JMP_TAKEN 1 cycle.
//    At PC=16'hFFFF, unconditional JR of +1 -> PC=16'h0001.
//  3 JP U8H.RBL: U8=8'h12, REGB_DATA[7:0]=8'h34 -> PC=16'h1234, REGB_SEL_RB=1 from DECODE.
//  4 Conditional, SKIPF=2'b10, CCF=1:
//    - FLAGS=4'b0010 -> taken.
//    - SKIPF=2'b11, same flags -> PC+1, no pulse.
//    - FLAGS change in COMMIT -> no effect.
//  5 HALT -> HALTED=1, PC frozen 20 cycles despite INSTR_VALID. WAKE -> FETCH at old PC+1.
//    STALL held 5 cycles in EXECUTE -> COMMIT delayed exactly 5.
//    RESET asserted in EXECUTE -> immediate reset state.
//  6 (JUMP_RSTACK_EN, DEPTH=4) 5 nested CALLs then 5 RETs:
//    - 4 RETs return correctly; RSTACK_OVF=1 after the 5th CALL.
//    - The 5th RET goes to PC+1 and sets RSTACK_UNF.

Source files
------------

// File: rtl/jump_sequencer_pkg.sv
// Shared definitions for the jump-group sequencer: instruction group codes,
// the HALT opcode, the phase FSM encoding and the IR field layout.
package jump_sequencer_pkg;

  localparam logic [1:0]  GROUP_JUMP       = 2'b10;
  localparam logic [15:0] INSTRUCTION_HALT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_HALT    = 3'd4
  } seq_state_t;

  // IR layout: GPF=[15:14], SKIPF=[13:12], JPF=[11:10], CCF=[9:8], U8=[7:0]
  typedef struct packed {
    logic [1:0] gpf;
    logic [1:0] skipf;
    logic [1:0] jpf;
    logic [1:0] ccf;
    logic [7:0] u8;
  } instr_t;

  function automatic instr_t decode_ir(input logic [15:0] ir);
    return instr_t'(ir);
  endfunction

endpackage

// File: rtl/jump_sequencer_rstack.sv
// Circular return-address stack used by CALL/RET. A push into a full stack
// drops the oldest entry; a pop from an empty stack leaves state untouched.
// Both conditions raise sticky flags cleared only by reset.
module jump_rstack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_ovf,
  output logic         o_unf
);

  localparam int unsigned    PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned    SLOTS    = 1 << PTR_W;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     r_mem [SLOTS];
  logic [PTR_W-1:0] r_sp;
  logic [PTR_W:0]   r_cnt;
  logic             r_ovf;
  logic             r_unf;
  logic [PTR_W-1:0] w_top;

  // r_sp is the next free slot; when full it also points at the oldest entry,
  // so a push there overwrites it naturally.
  assign w_top   = r_sp - PTR_W'(1);
  assign o_data  = r_mem[w_top];
  assign o_full  = (r_cnt == CNT_FULL);
  assign o_empty = (r_cnt == '0);
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;

  // Stack pointer, occupancy and sticky error flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (i_push) begin
      r_sp <= r_sp + PTR_W'(1);
      if (o_full) begin
        r_ovf <= 1'b1;
      end else begin
        r_cnt <= r_cnt + (PTR_W + 1)'(1);
      end
    end else if (i_pop) begin
      if (o_empty) begin
        r_unf <= 1'b1;
      end else begin
        r_sp  <= w_top;
        r_cnt <= r_cnt - (PTR_W + 1)'(1);
      end
    end
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_sp] <= i_data;
    end
  end

endmodule

// File: rtl/jump_sequencer.sv
// Jump-group sequencer: owns the PC, runs the FETCH/DECODE/EXECUTE/COMMIT
// phase FSM, evaluates Group-2 JP/JR jumps and handles HALT/WAKE and STALL.
// Optional feature macro: JUMP_RSTACK_EN adds CALL/RET through jump_rstack
// and the RSTACK_OVF/RSTACK_UNF ports.
module jump_sequencer
  import jump_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       NUM_CC       = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned       RSTACK_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [15:0]       INSTRUCTION,
  input  logic              INSTR_VALID,
  input  logic [ADDR_W-1:0] REGB_DATA,
  input  logic [NUM_CC-1:0] FLAGS,
  input  logic              STALL,
  input  logic              WAKE,
  output logic [ADDR_W-1:0] PC,
  output logic              PC_VALID,
  output logic              FETCH,
  output logic              DECODE,
  output logic              EXECUTE,
  output logic              COMMIT,
  output logic              REGB_SEL_RB,
  output logic              JMP_TAKEN,
  output logic              HALTED
`ifdef JUMP_RSTACK_EN
  ,
  output logic              RSTACK_OVF,
  output logic              RSTACK_UNF
`endif
);

  if (ADDR_W < 8 || ADDR_W > 32 || NUM_CC < 1 || NUM_CC > 4 ||
      RSTACK_DEPTH == 0 || (RSTACK_DEPTH & (RSTACK_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("jump_sequencer: unsupported parameter set");
  end

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [15:0]       r_ir;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_operand;
  logic [3:0]        r_flags;

  instr_t            w_ir;
  logic [3:0]        w_flags_in;
  logic [ADDR_W-1:0] w_u8rb;
  logic [ADDR_W-1:0] w_operand_in;
  logic [ADDR_W-1:0] w_jr_off;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_is_jump;
  logic              w_cond;
  logic              w_take;
  logic              w_commit;

  assign w_ir      = decode_ir(r_ir);
  assign w_is_jump = (w_ir.gpf == GROUP_JUMP);
  assign w_commit  = (r_state == ST_COMMIT);

  // Unimplemented flag indices alias flag 0, giving a fixed 4-entry view
  for (genvar g = 0; g < 4; g++) begin : g_flags
    if (g < NUM_CC) begin : g_real
      assign w_flags_in[g] = FLAGS[g];
    end else begin : g_alias
      assign w_flags_in[g] = FLAGS[0];
    end
  end

  // U8H.RBL operand and JR offset: a 16-bit offset is sign-extended on wide
  // PCs; on narrow PCs the truncated operand already equals the offset mod 2^ADDR_W.
  if (ADDR_W > 16) begin : g_wide
    assign w_u8rb   = {{(ADDR_W-16){1'b0}}, w_ir.u8, REGB_DATA[7:0]};
    assign w_jr_off = {{(ADDR_W-16){r_operand[15]}}, r_operand[15:0]};
  end else if (ADDR_W == 16) begin : g_16
    assign w_u8rb   = {w_ir.u8, REGB_DATA[7:0]};
    assign w_jr_off = r_operand;
  end else if (ADDR_W > 8) begin : g_narrow
    assign w_u8rb   = {w_ir.u8[ADDR_W-9:0], REGB_DATA[7:0]};
    assign w_jr_off = r_operand;
  end else begin : g_8
    assign w_u8rb   = REGB_DATA[7:0];
    assign w_jr_off = r_operand;
  end

  assign w_operand_in = w_ir.jpf[0] ? w_u8rb : REGB_DATA;
  assign w_pc_inc     = r_pc + ADDR_W'(1);
  assign w_target     = w_ir.jpf[1] ? (w_pc_inc + w_jr_off) : r_operand;
  assign w_cond       = w_ir.skipf[1] ? (r_flags[w_ir.ccf] ^ w_ir.skipf[0]) : 1'b1;
  assign w_take       = w_is_jump & w_cond;

`ifdef JUMP_RSTACK_EN
  localparam logic [1:0] SKIPF_STACK = 2'b01;
  localparam logic [1:0] JPF_RET     = 2'b11;

  logic              w_stack_op;
  logic              w_ret;
  logic              w_call;
  logic              w_rs_full;
  logic              w_rs_empty;
  logic [ADDR_W-1:0] w_rs_data;

  assign w_stack_op = w_is_jump & (w_ir.skipf == SKIPF_STACK);
  assign w_ret      = w_stack_op & (w_ir.jpf == JPF_RET);
  assign w_call     = w_stack_op & (w_ir.jpf != JPF_RET);

  jump_rstack #(
    .DEPTH (RSTACK_DEPTH),
    .W     (ADDR_W)
  ) u_rstack (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_push  (w_commit & w_call),
    .i_pop   (w_commit & w_ret),
    .i_data  (w_pc_inc),
    .o_data  (w_rs_data),
    .o_full  (w_rs_full),
    .o_empty (w_rs_empty),
    .o_ovf   (RSTACK_OVF),
    .o_unf   (RSTACK_UNF)
  );

  // RET returns the popped address, or falls through when the stack is empty
  always_comb begin
    w_pc_nxt = w_pc_inc;
    if (w_ret) begin
      w_pc_nxt = w_rs_empty ? w_pc_inc : w_rs_data;
    end else if (w_take) begin
      w_pc_nxt = w_target;
    end
  end
`else
  assign w_pc_nxt = w_take ? w_target : w_pc_inc;
`endif

  // Phase state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Phase sequencing; STALL only matters in EXECUTE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH:   if (INSTR_VALID) w_state_nxt = ST_DECODE;
      ST_DECODE:  w_state_nxt = ST_EXECUTE;
      ST_EXECUTE: if (!STALL) w_state_nxt = ST_COMMIT;
      ST_COMMIT:  w_state_nxt = (r_ir == INSTRUCTION_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:    if (WAKE) w_state_nxt = ST_FETCH;
      default:    w_state_nxt = ST_FETCH;
    endcase
  end

  // IR capture, operand/flag snapshot in EXECUTE, PC update in COMMIT
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pc      <= RESET_VECTOR;
      r_ir      <= '0;
      r_operand <= '0;
      r_flags   <= '0;
    end else begin
      if (r_state == ST_FETCH && INSTR_VALID) begin
        r_ir <= INSTRUCTION;
      end
      if (r_state == ST_EXECUTE) begin
        r_operand <= w_operand_in;
        r_flags   <= w_flags_in;
      end
      if (w_commit) begin
        r_pc <= w_pc_nxt;
      end
    end
  end

  assign PC          = r_pc;
  assign FETCH       = (r_state == ST_FETCH);
  assign DECODE      = (r_state == ST_DECODE);
  assign EXECUTE     = (r_state == ST_EXECUTE);
  assign COMMIT      = w_commit;
  assign HALTED      = (r_state == ST_HALT);
  assign PC_VALID    = FETCH;
  assign JMP_TAKEN   = w_commit & w_take;
  // RB select is held from DECODE so REGB_DATA is settled by the EXECUTE snapshot
  assign REGB_SEL_RB = w_is_jump & w_ir.jpf[0] & (DECODE | EXECUTE | COMMIT);

endmodule

// File: tb/tb_jump_sequencer.sv
// Directed self-checking bench for jump_sequencer. Covers the return-stack
// scenario as well when JUMP_RSTACK_EN is defined.
module tb_jump_sequencer;

  logic        CLK;
  logic        RESET;
  logic [15:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic [15:0] REGB_DATA;
  logic [3:0]  FLAGS;
  logic        STALL;
  logic        WAKE;
  logic [15:0] PC;
  logic        PC_VALID;
  logic        FETCH;
  logic        DECODE;
  logic        EXECUTE;
  logic        COMMIT;
  logic        REGB_SEL_RB;
  logic        JMP_TAKEN;
  logic        HALTED;
`ifdef JUMP_RSTACK_EN
  logic        RSTACK_OVF;
  logic        RSTACK_UNF;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0]  ph_log [4];
  logic        tk_log [4];
  logic        sel_dec;
  logic [15:0] uj_instr;

  jump_sequencer #(
    .ADDR_W       (16),
    .NUM_CC       (4),
    .RESET_VECTOR (16'h0100),
    .RSTACK_DEPTH (4)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .INSTR_VALID (INSTR_VALID),
    .REGB_DATA   (REGB_DATA),
    .FLAGS       (FLAGS),
    .STALL       (STALL),
    .WAKE        (WAKE),
    .PC          (PC),
    .PC_VALID    (PC_VALID),
    .FETCH       (FETCH),
    .DECODE      (DECODE),
    .EXECUTE     (EXECUTE),
    .COMMIT      (COMMIT),
    .REGB_SEL_RB (REGB_SEL_RB),
    .JMP_TAKEN   (JMP_TAKEN),
    .HALTED      (HALTED)
`ifdef JUMP_RSTACK_EN
    ,
    .RSTACK_OVF  (RSTACK_OVF),
    .RSTACK_UNF  (RSTACK_UNF)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instruction from a FETCH negedge to the following negedge after COMMIT.
  // flg_c is applied during COMMIT; stall_out drives STALL outside EXECUTE.
  task automatic run_instr(input logic [15:0] instr, input logic [15:0] regb,
                           input logic [3:0] flg, input logic [3:0] flg_c,
                           input logic stall_out);
    INSTRUCTION = instr;
    REGB_DATA   = regb;
    FLAGS       = flg;
    STALL       = stall_out;
    INSTR_VALID = 1'b1;
    ph_log[0] = {FETCH, DECODE, EXECUTE, COMMIT};
    tk_log[0] = JMP_TAKEN;
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    ph_log[1] = {FETCH, DECODE, EXECUTE, COMMIT};
    tk_log[1] = JMP_TAKEN;
    sel_dec   = REGB_SEL_RB;
    @(negedge CLK);
    STALL = 1'b0;
    ph_log[2] = {FETCH, DECODE, EXECUTE, COMMIT};
    tk_log[2] = JMP_TAKEN;
    @(negedge CLK);
    STALL = stall_out;
    FLAGS = flg_c;
    #1;
    ph_log[3] = {FETCH, DECODE, EXECUTE, COMMIT};
    tk_log[3] = JMP_TAKEN;
    @(negedge CLK);
    STALL = 1'b0;
  endtask

  task automatic check_cycle(input string tag, input logic exp_tk);
    logic [3:0] e;
    for (int i = 0; i < 4; i++) begin
      e = 4'b1000 >> i;
      check($sformatf("%s_ph%0d", tag, i), 32'(ph_log[i]), 32'(e));
    end
    check({tag, "_tk"}, 32'({tk_log[0], tk_log[1], tk_log[2], tk_log[3]}), 32'({3'b000, exp_tk}));
  endtask

  initial begin
    RESET = 1'b1; INSTRUCTION = '0; INSTR_VALID = 1'b0; REGB_DATA = '0;
    FLAGS = '0; STALL = 1'b0; WAKE = 1'b0;
`ifdef JUMP_RSTACK_EN
    uj_instr = 16'h8000;
`else
    uj_instr = 16'h9000;
`endif
    repeat (2) @(negedge CLK);

    // reset state
    check("rst_pc", 32'(PC), 32'h0100);
    check("rst_outs", 32'({PC_VALID, FETCH, DECODE, EXECUTE, COMMIT, REGB_SEL_RB, JMP_TAKEN, HALTED}),
          32'h0000_00C0);
    RESET = 1'b0;

    // three NOPs, second with STALL driven outside EXECUTE
    run_instr(16'h0000, 16'h0000, 4'h0, 4'h0, 1'b0);
    check_cycle("nop0", 1'b0);
    check("nop0_pc", 32'(PC), 32'h0101);
    run_instr(16'h0000, 16'h0000, 4'h0, 4'h0, 1'b1);
    check_cycle("nop1_stall_ignored", 1'b0);
    check("nop1_pc", 32'(PC), 32'h0102);
    run_instr(16'h0000, 16'h0000, 4'h0, 4'h0, 1'b0);
    check("nop2_pc", 32'(PC), 32'h0103);

    // JP register to 0010, then JR -2
    run_instr(16'h8000, 16'h0010, 4'h0, 4'h0, 1'b0);
    check("jp_reg_pc", 32'(PC), 32'h0010);
    check("jp_reg_sel", 32'(sel_dec), 32'h0);
    run_instr(16'h8800, 16'hFFFE, 4'h0, 4'h0, 1'b0);
    check_cycle("jr_back", 1'b1);
    check("jr_back_pc", 32'(PC), 32'h000F);
    check("jr_tk_after", 32'(JMP_TAKEN), 32'h0);

    // JR +1 from FFFF wraps
    run_instr(16'h8000, 16'hFFFF, 4'h0, 4'h0, 1'b0);
    check("jp_ffff_pc", 32'(PC), 32'hFFFF);
    run_instr(16'h8800, 16'h0001, 4'h0, 4'h0, 1'b0);
    check("jr_wrap_pc", 32'(PC), 32'h0001);
    check("jr_wrap_tk", 32'(tk_log[3]), 32'h1);

    // JP U8H.RBL
    run_instr(16'h8412, 16'hAB34, 4'h0, 4'h0, 1'b0);
    check("jp_u8rb_pc", 32'(PC), 32'h1234);
    check("jp_u8rb_sel", 32'(sel_dec), 32'h1);
    check("jp_u8rb_tk", 32'(tk_log[3]), 32'h1);

    // conditional jumps on CCF=1
    run_instr(16'hA100, 16'h2000, 4'b0010, 4'b0010, 1'b0);
    check("cond_taken_pc", 32'(PC), 32'h2000);
    check("cond_taken_tk", 32'(tk_log[3]), 32'h1);
    run_instr(16'hB100, 16'h3000, 4'b0010, 4'b0010, 1'b0);
    check("cond_inv_pc", 32'(PC), 32'h2001);
    check("cond_inv_tk", 32'(tk_log[3]), 32'h0);
    run_instr(16'hA100, 16'h4000, 4'b0010, 4'b0000, 1'b0);
    check("flags_commit_drop_pc", 32'(PC), 32'h4000);
    check("flags_commit_drop_tk", 32'(tk_log[3]), 32'h1);
    run_instr(16'hA100, 16'h5000, 4'b0000, 4'b0010, 1'b0);
    check("flags_commit_rise_pc", 32'(PC), 32'h4001);
    check("flags_commit_rise_tk", 32'(tk_log[3]), 32'h0);
    run_instr(16'hA100, 16'h6000, 4'b1101, 4'b1101, 1'b0);
    check("cond_other_flags_pc", 32'(PC), 32'h4002);
    run_instr(16'h4800, 16'h5555, 4'hF, 4'hF, 1'b0);
    check("nonjump_pc", 32'(PC), 32'h4003);
    check("nonjump_tk", 32'(tk_log[3]), 32'h0);
    run_instr(uj_instr, 16'h4100, 4'h0, 4'h0, 1'b0);
    check("uncond_pc", 32'(PC), 32'h4100);
    check("uncond_tk", 32'(tk_log[3]), 32'h1);

    // HALT, frozen PC, WAKE
    run_instr(16'hFFFF, 16'h0000, 4'h0, 4'h0, 1'b0);
    check("halt_state", 32'({HALTED, PC_VALID, FETCH, DECODE, EXECUTE, COMMIT}), 32'h20);
    check("halt_pc", 32'(PC), 32'h4101);
    INSTRUCTION = 16'h8000;
    INSTR_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check($sformatf("halt_hold%0d", i), 32'({PC, HALTED}), 32'({16'h4101, 1'b1}));
    end
    INSTR_VALID = 1'b0;
    WAKE = 1'b1;
    @(negedge CLK);
    WAKE = 1'b0;
    check("wake_state", 32'({HALTED, FETCH, PC_VALID}), 32'h3);
    check("wake_pc", 32'(PC), 32'h4101);

    // STALL for 5 cycles in EXECUTE
    INSTRUCTION = 16'h0000;
    INSTR_VALID = 1'b1;
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    @(negedge CLK);
    check("stall_exec_entry", 32'(EXECUTE), 32'h1);
    STALL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check($sformatf("stall_hold%0d", i), 32'({EXECUTE, COMMIT}), 32'h2);
    end
    STALL = 1'b0;
    @(negedge CLK);
    check("stall_commit", 32'({EXECUTE, COMMIT}), 32'h1);
    @(negedge CLK);
    check("stall_pc", 32'({PC, FETCH}), 32'({16'h4102, 1'b1}));

    // RESET in EXECUTE aborts the jump
    INSTRUCTION = 16'h8000;
    REGB_DATA   = 16'h7777;
    INSTR_VALID = 1'b1;
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("rst_exec_pc", 32'(PC), 32'h0100);
    check("rst_exec_outs", 32'({FETCH, DECODE, EXECUTE, COMMIT, JMP_TAKEN}), 32'h10);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_exec_after", 32'({PC, FETCH}), 32'({16'h0100, 1'b1}));

    // WAKE together with RESET
    run_instr(16'hFFFF, 16'h0000, 4'h0, 4'h0, 1'b0);
    check("halt2_pc", 32'({PC, HALTED}), 32'({16'h0101, 1'b1}));
    RESET = 1'b1;
    WAKE  = 1'b1;
    #1;
    check("wake_rst", 32'({PC, HALTED, FETCH}), 32'({16'h0100, 2'b01}));
    @(negedge CLK);
    RESET = 1'b0;
    WAKE  = 1'b0;

`ifdef JUMP_RSTACK_EN
    // five nested CALLs into a four-deep stack, then five RETs
    check("rs_init", 32'({RSTACK_OVF, RSTACK_UNF}), 32'h0);
    for (int i = 0; i < 5; i++) begin
      run_instr(16'h9000, 16'((i + 1) << 12), 4'h0, 4'h0, 1'b0);
      check($sformatf("call%0d_pc", i), 32'(PC), 32'((i + 1) << 12));
      check($sformatf("call%0d_tk", i), 32'(tk_log[3]), 32'h1);
      check($sformatf("call%0d_ovf", i), 32'(RSTACK_OVF), 32'(i == 4));
    end
    for (int i = 0; i < 4; i++) begin
      run_instr(16'h9C00, 16'h0000, 4'h0, 4'h0, 1'b0);
      check($sformatf("ret%0d_pc", i), 32'(PC), 32'(((4 - i) << 12) + 1));
      check($sformatf("ret%0d_tk", i), 32'(tk_log[3]), 32'h1);
      check($sformatf("ret%0d_unf", i), 32'(RSTACK_UNF), 32'h0);
    end
    run_instr(16'h9C00, 16'h0000, 4'h0, 4'h0, 1'b0);
    check("ret4_pc", 32'(PC), 32'h1002);
    check("ret4_unf", 32'(RSTACK_UNF), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
